// File: rtl/dsp_mac_pkg.sv
// Shared definitions for the multi-channel multiply-accumulate pipeline.
//   - Pre-op encodings (mode[1:0]) selecting the pre-adder result
//   - Post-op encodings (mode[3:2]) selecting the post-adder behaviour
//   - ch_width(): channel index width, never narrower than one bit
package dsp_mac_pkg;

  // Pre-adder operation, mode[1:0]
  localparam logic [1:0] PRE_B    = 2'b00;  // B
  localparam logic [1:0] PRE_ADD  = 2'b01;  // D + B
  localparam logic [1:0] PRE_SUB  = 2'b10;  // D - B
  localparam logic [1:0] PRE_ZERO = 2'b11;  // 0

  // Post-adder operation, mode[3:2]
  localparam logic [1:0] POST_LOAD  = 2'b00;  // P = M + C, acc[ch] <= P
  localparam logic [1:0] POST_ACC   = 2'b01;  // P = acc[ch] + M, acc[ch] <= P
  localparam logic [1:0] POST_PASSC = 2'b10;  // P = C, acc untouched
  localparam logic [1:0] POST_CLEAR = 2'b11;  // P = 0, acc[ch] <= 0

  // A single channel still needs a one-bit index port.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dsp_acc_bank.sv
// Accumulator register file: NCH entries of PW bits.
//   clk_i      rising-edge clock
//   rst_i      synchronous active-high reset, clears every entry
//   rd_addr_i  combinational read index; out-of-range indices read 0
//   rd_data_o  read data
//   we_i       write enable
//   wr_addr_i  write index; out-of-range indices are ignored
//   wr_data_i  write data
module dsp_acc_bank
  import dsp_mac_pkg::*;
#(
  parameter int unsigned NCH = 4,
  parameter int unsigned PW  = 48,
  parameter int unsigned CHW = ch_width(NCH)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [CHW-1:0] rd_addr_i,
  output logic [PW-1:0]  rd_data_o,
  input  logic           we_i,
  input  logic [CHW-1:0] wr_addr_i,
  input  logic [PW-1:0]  wr_data_i
);

  logic [PW-1:0] acc_q [NCH];

  // Compare against every index rather than array-indexing so that a
  // non-power-of-two NCH never reads or writes past the end of the bank.
  always_comb begin
    rd_data_o = '0;
    for (int unsigned n = 0; n < NCH; n++) begin
      if (rd_addr_i == CHW'(n)) begin
        rd_data_o = acc_q[n];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned n = 0; n < NCH; n++) begin
        acc_q[n] <= '0;
      end
    end else if (we_i) begin
      for (int unsigned n = 0; n < NCH; n++) begin
        if (wr_addr_i == CHW'(n)) begin
          acc_q[n] <= wr_data_i;
        end
      end
    end
  end

endmodule

// File: rtl/dsp_mac_pipe.sv
// Three-stage signed pre-add / multiply / post-add pipeline with NCH
// time-multiplexed accumulator channels and valid/ready flow control.
//   clk        rising-edge clock
//   RST        synchronous active-high reset
//   in_valid   sample valid          in_ready   sample accepted this cycle
//   A          multiplier operand    B, D       pre-adder operands
//   C          post-adder operand    ch         accumulator channel
//   mode       [1:0] pre-op, [3:2] post-op
//   out_valid  result valid          out_ready  consumer accepts result
//   P          result                P_ch       channel of result
//   P_ovf      signed overflow of the post-add (clamped when SAT=1)
module dsp_mac_pipe
  import dsp_mac_pkg::*;
#(
  parameter int unsigned AW  = 18,
  parameter int unsigned BW  = 18,
  parameter int unsigned CW  = 48,
  parameter int unsigned PW  = 48,
  parameter int unsigned NCH = 4,
  parameter int unsigned SAT = 0,
  localparam int unsigned CHW = ch_width(NCH)
) (
  input  logic           clk,
  input  logic           RST,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [AW-1:0]  A,
  input  logic [BW-1:0]  B,
  input  logic [BW-1:0]  D,
  input  logic [CW-1:0]  C,
  input  logic [CHW-1:0] ch,
  input  logic [3:0]     mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [PW-1:0]  P,
  output logic [CHW-1:0] P_ch,
  output logic           P_ovf
);

  localparam int unsigned PRW = BW + 1;       // pre-adder result width
  localparam int unsigned MW  = AW + BW + 1;  // product width

  localparam logic [PW-1:0] PMAX = {1'b0, {(PW-1){1'b1}}};
  localparam logic [PW-1:0] PMIN = {1'b1, {(PW-1){1'b0}}};

  // Single global enable: the whole pipe moves or the whole pipe holds.
  logic adv;
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  // ---------------------------------------------------------------- S1
  logic           s1_valid_q;
  logic [AW-1:0]  s1_a_q;
  logic [BW-1:0]  s1_b_q;
  logic [BW-1:0]  s1_d_q;
  logic [CW-1:0]  s1_c_q;
  logic [1:0]     s1_pre_q;
  logic [1:0]     s1_post_q;
  logic [CHW-1:0] s1_ch_q;

  // ---------------------------------------------------------------- S2
  logic           s2_valid_q;
  logic [MW-1:0]  s2_m_q;
  logic [CW-1:0]  s2_c_q;
  logic [1:0]     s2_post_q;
  logic [CHW-1:0] s2_ch_q;

  // ---------------------------------------------------------------- S3
  logic           p_valid_q;
  logic [PW-1:0]  p_q;
  logic [CHW-1:0] p_ch_q;
  logic           p_ovf_q;

  // Pre-add is one bit wider than its operands so D+B and D-B never wrap.
  logic signed [PRW-1:0] b_ext, d_ext, pre_res;
  logic signed [MW-1:0]  a_mul, pre_mul, prod;

  always_comb begin
    b_ext   = PRW'($signed(s1_b_q));
    d_ext   = PRW'($signed(s1_d_q));
    pre_res = '0;
    unique case (s1_pre_q)
      PRE_B:    pre_res = b_ext;
      PRE_ADD:  pre_res = d_ext + b_ext;
      PRE_SUB:  pre_res = d_ext - b_ext;
      PRE_ZERO: pre_res = '0;
      default:  pre_res = '0;
    endcase
    a_mul   = MW'($signed(s1_a_q));
    pre_mul = MW'(pre_res);
    prod    = a_mul * pre_mul;
  end

  // Post-adder, reading the accumulator combinationally so a sample that
  // follows on the same channel sees the value written at this same edge.
  logic [PW-1:0] acc_rd;
  logic [PW-1:0] m_ext, c_ext;
  logic [PW-1:0] add_x, add_y;
  logic [PW:0]   sum;
  logic          use_add;
  logic [PW-1:0] post_res;
  logic          post_ovf;
  logic          acc_we;

  always_comb begin
    m_ext    = PW'($signed(s2_m_q));
    c_ext    = PW'($signed(s2_c_q));
    add_x    = m_ext;
    add_y    = c_ext;
    use_add  = 1'b0;
    post_res = '0;
    post_ovf = 1'b0;
    unique case (s2_post_q)
      POST_LOAD: begin
        add_x   = m_ext;
        add_y   = c_ext;
        use_add = 1'b1;
      end
      POST_ACC: begin
        add_x   = acc_rd;
        add_y   = m_ext;
        use_add = 1'b1;
      end
      POST_PASSC: post_res = c_ext;
      POST_CLEAR: post_res = '0;
      default:    post_res = '0;
    endcase
    // One guard bit: overflow when the guard and the PW-bit sign disagree,
    // and the guard bit carries the true sign for clamping.
    sum = {add_x[PW-1], add_x} + {add_y[PW-1], add_y};
    if (use_add) begin
      post_ovf = sum[PW] ^ sum[PW-1];
      if (post_ovf && (SAT != 0)) begin
        post_res = sum[PW] ? PMIN : PMAX;
      end else begin
        post_res = sum[PW-1:0];
      end
    end
    // PASSC leaves the bank alone; CLEAR writes the zero post_res.
    acc_we = s2_valid_q && adv && (s2_post_q != POST_PASSC);
  end

  dsp_acc_bank #(
    .NCH (NCH),
    .PW  (PW),
    .CHW (CHW)
  ) u_acc_bank (
    .clk_i     (clk),
    .rst_i     (RST),
    .rd_addr_i (s2_ch_q),
    .rd_data_o (acc_rd),
    .we_i      (acc_we),
    .wr_addr_i (s2_ch_q),
    .wr_data_i (post_res)
  );

  // Valid bits and result registers; reset wins over adv.
  always_ff @(posedge clk) begin
    if (RST) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      p_valid_q  <= 1'b0;
      p_q        <= '0;
      p_ch_q     <= '0;
      p_ovf_q    <= 1'b0;
    end else if (adv) begin
      s1_valid_q <= in_valid;
      s2_valid_q <= s1_valid_q;
      p_valid_q  <= s2_valid_q;
      // Bubbles leave the last result on P rather than loading junk.
      if (s2_valid_q) begin
        p_q     <= post_res;
        p_ch_q  <= s2_ch_q;
        p_ovf_q <= post_ovf;
      end
    end
  end

  // Datapath payload needs no reset: it is qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_a_q    <= A;
      s1_b_q    <= B;
      s1_d_q    <= D;
      s1_c_q    <= C;
      s1_pre_q  <= mode[1:0];
      s1_post_q <= mode[3:2];
      s1_ch_q   <= ch;
      s2_m_q    <= prod;
      s2_c_q    <= s1_c_q;
      s2_post_q <= s1_post_q;
      s2_ch_q   <= s1_ch_q;
    end
  end

  assign out_valid = p_valid_q;
  assign P         = p_q;
  assign P_ch      = p_ch_q;
  assign P_ovf     = p_ovf_q;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
module tb_dsp_mac_pipe;
  import dsp_mac_pkg::*;

  localparam int AW  = 18;
  localparam int BW  = 18;
  localparam int CW  = 48;
  localparam int PW  = 48;
  localparam int NCH = 4;
  localparam int CHW = 2;

  localparam longint PMAX = 64'sd140737488355327;   // 2^47-1
  localparam longint PMIN = -64'sd140737488355328;  // -2^47

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, in_valid, out_ready;
  logic [AW-1:0]  a;
  logic [BW-1:0]  b, d;
  logic [CW-1:0]  c;
  logic [CHW-1:0] ch;
  logic [3:0]     mode;

  logic           in_ready_w, in_ready_s, out_valid_w, out_valid_s;
  logic [PW-1:0]  p_w, p_s;
  logic [CHW-1:0] pch_w, pch_s;
  logic           ovf_w, ovf_s;

  dsp_mac_pipe #(
    .AW(AW), .BW(BW), .CW(CW), .PW(PW), .NCH(NCH), .SAT(0)
  ) u_wrap (
    .clk(clk), .RST(rst), .in_valid(in_valid), .in_ready(in_ready_w),
    .A(a), .B(b), .D(d), .C(c), .ch(ch), .mode(mode),
    .out_valid(out_valid_w), .out_ready(out_ready),
    .P(p_w), .P_ch(pch_w), .P_ovf(ovf_w)
  );

  dsp_mac_pipe #(
    .AW(AW), .BW(BW), .CW(CW), .PW(PW), .NCH(NCH), .SAT(1)
  ) u_sat (
    .clk(clk), .RST(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .A(a), .B(b), .D(d), .C(c), .ch(ch), .mode(mode),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .P(p_s), .P_ch(pch_s), .P_ovf(ovf_s)
  );

  typedef struct {
    logic [AW-1:0]  a;
    logic [BW-1:0]  b;
    logic [BW-1:0]  d;
    logic [CW-1:0]  c;
    logic [CHW-1:0] ch;
    logic [3:0]     mode;
    logic [PW-1:0]  pw;   // expected P, wrapping instance
    logic [PW-1:0]  ps;   // expected P, saturating instance
    logic           ow;
    logic           os;
    int             lat;  // 0 = latency not checked
  } vec_t;

  typedef struct {
    logic [PW-1:0]  pw;
    logic [PW-1:0]  ps;
    logic           ow;
    logic           os;
    logic [CHW-1:0] ch;
    int             lat;
    int             cyc;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input int va, input int vb, input int vd, input longint vc,
                              input int vch, input logic [1:0] pre, input logic [1:0] post,
                              input longint epw, input longint eps, input bit eow,
                              input bit eos, input int lat);
    vec_t v;
    v.a    = va[AW-1:0];
    v.b    = vb[BW-1:0];
    v.d    = vd[BW-1:0];
    v.c    = vc[CW-1:0];
    v.ch   = vch[CHW-1:0];
    v.mode = {post, pre};
    v.pw   = epw[PW-1:0];
    v.ps   = eps[PW-1:0];
    v.ow   = eow;
    v.os   = eos;
    v.lat  = lat;
    return v;
  endfunction

  // Drive one sample, hold it until accepted, optionally scoreboard it.
  task automatic send(input vec_t v, input bit track);
    int   n;
    exp_t e;
    a = v.a; b = v.b; d = v.d; c = v.c; ch = v.ch; mode = v.mode;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready_w && n < 50);
    if (!in_ready_w) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready got 0 expected 1 within 50 cycles");
    end else if (track) begin
      e.pw = v.pw; e.ps = v.ps; e.ow = v.ow; e.os = v.os;
      e.ch = v.ch; e.lat = v.lat; e.cyc = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("drain_outstanding", 64'(sb.size()), 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Results are consumed at the posedge that follows a negedge seeing
  // out_valid & out_ready, so each result is compared exactly once.
  always @(negedge clk) begin
    if (!rst && out_valid_w && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got P=%0h expected no result", p_w);
      end else begin
        mon_e = sb.pop_front();
        chk("p_wrap", 64'(p_w), 64'(mon_e.pw));
        chk("ovf_wrap", 64'(ovf_w), 64'(mon_e.ow));
        chk("p_ch", 64'(pch_w), 64'(mon_e.ch));
        chk("sat_valid", 64'(out_valid_s), 64'd1);
        chk("p_sat", 64'(p_s), 64'(mon_e.ps));
        chk("ovf_sat", 64'(ovf_s), 64'(mon_e.os));
        chk("p_ch_sat", 64'(pch_s), 64'(mon_e.ch));
        if (mon_e.lat != 0) chk("latency", 64'(cyc - mon_e.cyc), 64'(mon_e.lat));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; d = '0; c = '0; ch = '0; mode = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_p", 64'(p_w), 64'd0);
    chk("rst_out_valid", 64'(out_valid_w), 64'd0);
    chk("rst_in_ready", 64'(in_ready_w), 64'd1);
    chk("rst_p_sat", 64'(p_s), 64'd0);

    // a, b, d, c, ch, pre, post, P wrap, P sat, ovf wrap, ovf sat, latency
    vecs.push_back(mk(100, 5, 20, 7, 0, PRE_SUB, POST_LOAD, 1507, 1507, 0, 0, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, PRE_B, POST_CLEAR, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, PRE_B, POST_CLEAR, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 4; i++) begin
      vecs.push_back(mk(1, 10, 0, 0, 0, PRE_B, POST_ACC, 10 * i, 10 * i, 0, 0, 0));
      vecs.push_back(mk(1, -4, 0, 0, 1, PRE_B, POST_ACC, -4 * i, -4 * i, 0, 0, 0));
    end
    vecs.push_back(mk(2, 1, 0, 0, 0, PRE_B, POST_ACC, 42, 42, 0, 0, 0));
    vecs.push_back(mk(2, 1, 0, 0, 0, PRE_B, POST_ACC, 44, 44, 0, 0, 0));
    vecs.push_back(mk(-3, 2, 7, 100, 3, PRE_ADD, POST_LOAD, 73, 73, 0, 0, 0));
    vecs.push_back(mk(5, 9, 1, -50, 3, PRE_ZERO, POST_LOAD, -50, -50, 0, 0, 0));
    vecs.push_back(mk(-7, 6, 0, 0, 3, PRE_B, POST_ACC, -92, -92, 0, 0, 0));
    vecs.push_back(mk(-131072, 131071, -131072, 0, 2, PRE_SUB, POST_LOAD,
                      64'sd34359607296, 64'sd34359607296, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 55, 2, PRE_B, POST_CLEAR, 0, 0, 0, 0, 0));
    vecs.push_back(mk(4, 4, 0, -9, 2, PRE_B, POST_PASSC, -9, -9, 0, 0, 0));
    vecs.push_back(mk(3, 3, 0, 0, 2, PRE_B, POST_ACC, 9, 9, 0, 0, 0));
    for (int i = 0; i < vecs.size(); i++) send(vecs[i], 1'b1);
    drain();

    // Reset with two samples in flight and a sample offered during reset.
    send(mk(1, 5, 0, 0, 0, PRE_B, POST_ACC, 0, 0, 0, 0, 0), 1'b0);
    send(mk(1, 5, 0, 0, 3, PRE_B, POST_ACC, 0, 0, 0, 0, 0), 1'b0);
    rst = 1'b1;
    in_valid = 1'b1; a = 18'd7; b = 18'd7; ch = 2'd0; mode = {POST_ACC, PRE_B};
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0;
    chk("midrst_p", 64'(p_w), 64'd0);
    chk("midrst_out_valid", 64'(out_valid_w), 64'd0);
    chk("midrst_in_ready", 64'(in_ready_w), 64'd1);
    send(mk(2, 3, 0, 0, 0, PRE_B, POST_ACC, 6, 6, 0, 0, 0), 1'b1);
    send(mk(1, 1, 0, 0, 3, PRE_B, POST_ACC, 1, 1, 0, 0, 0), 1'b1);
    drain();

    // Back-pressure: three samples in flight, consumer stalled 5 cycles.
    out_ready = 1'b0;
    send(mk(1, 1, 0, 10, 1, PRE_B, POST_LOAD, 11, 11, 0, 0, 0), 1'b1);
    send(mk(2, 2, 0, 0, 1, PRE_B, POST_LOAD, 4, 4, 0, 0, 0), 1'b1);
    send(mk(3, -1, 0, 1, 1, PRE_B, POST_LOAD, -2, -2, 0, 0, 0), 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_p", 64'(p_w), 64'd11);
      chk("stall_out_valid", 64'(out_valid_w), 64'd1);
      chk("stall_in_ready", 64'(in_ready_w), 64'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // Overflow: wrap versus clamp, and the clamped value persisting in acc.
    send(mk(0, 0, 0, PMAX, 3, PRE_ZERO, POST_LOAD, PMAX, PMAX, 0, 0, 0), 1'b1);
    send(mk(1, 1, 0, 0, 3, PRE_B, POST_ACC, PMIN, PMAX, 1, 1, 0), 1'b1);
    send(mk(1, 1, 0, 0, 3, PRE_B, POST_ACC, PMIN + 1, PMAX, 0, 1, 0), 1'b1);
    send(mk(0, 0, 0, PMIN, 2, PRE_ZERO, POST_LOAD, PMIN, PMIN, 0, 0, 0), 1'b1);
    send(mk(-1, 1, 0, 0, 2, PRE_B, POST_ACC, PMAX, PMIN, 1, 1, 0), 1'b1);
    send(mk(2, 1, 0, PMAX, 1, PRE_B, POST_LOAD, PMIN + 1, PMAX, 1, 1, 0), 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dsp_mac_pipe.md
# dsp_mac_pipe

Parametrised, multi-channel signed multiply-accumulate pipeline: the next generation of our DSP48A1-style slice. It keeps the pre-adder → multiplier → post-adder datapath but adds configurable widths, NCH time-multiplexed accumulator channels, per-sample mode, optional saturation, and valid/ready flow control. It sits between sample sources (filters, correlators) and downstream result consumers in the DSP datapath.

## Interface
- AW, 18, A operand width (signed)
- BW, 18, B and D operand width (signed)
- CW, 48, C operand width (signed)
- PW, 48, result/accumulator width; must satisfy PW ≥ AW+BW+1 and PW ≥ CW
- NCH, 4, number of accumulator channels (≥1)
- SAT, 0, 1 = saturate post-adder to signed PW range; 0 = wrap
- clk  in  1  clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  pipeline accepts sample this cycle
- A  in  AW  multiplier operand
- B  in  BW  pre-adder operand
- D  in  BW  pre-adder operand
- C  in  CW  post-adder operand
- ch  in  clog2(NCH) (min 1)  accumulator channel
- mode  in  4  [1:0] pre-op, [3:2] post-op
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- P  out  PW  result
- P_ch  out  clog2(NCH)  channel of result
- P_ovf  out  1  overflow/saturation occurred on this result

## Operation
- Pre-op: 00 → B; 01 → D+B; 10 → D−B; 11 → 0. Result BW+1 bits signed, no wrap.
- Multiply: M = A × pre-op result, AW+BW+1 bits signed, sign-extended to PW.
- Post-op: 00 LOAD: P = M + C, writes acc[ch]; 01 ACC: P = acc[ch] + M, writes acc[ch]; 10 PASSC: P = C, acc untouched; 11 CLEAR: P = 0, acc[ch] = 0.
- C sign-extended to PW.
- Overflow: signed overflow of the PW-bit post-add.
  - SAT=1: P clamps to 2^(PW−1)−1 or −2^(PW−1), and the clamped value is written to acc.
  - SAT=0: P wraps.
  - P_ovf = 1 in both cases.
- Accumulator bank is read combinationally at stage 3 and written at the stage-3 edge. Back-to-back samples on the same channel therefore see the updated value with no hazard or bubble.

## Timing
- Stages: S1 registers operands, mode and ch; S2 registers the pre-add and product; S3 registers P. Latency is 3 cycles from acceptance to out_valid when unstalled. Throughput is 1 sample/cycle.
- Global enable adv = !out_valid | out_ready. All stages, valid bits and acc writes advance only when adv=1.
- in_ready = adv. A sample is accepted on in_valid & in_ready.
- Bubbles: invalid slots propagate as bubbles. Bubbles never write acc.
- Stall: out_valid=1 & out_ready=0 holds P, P_ch and P_ovf stable and freezes every stage.
- Reset (RST=1 at an edge): all valid bits, P, P_ch, P_ovf and every acc[n] are cleared to 0. in_ready reads 1 in the first cycle after reset. RST overrides in-flight samples, which are dropped without writing acc.
- RST has priority over adv. in_valid during RST is ignored.

## Structure
- Package dsp_mac_pkg holds:
  - pre-op and post-op encodings as localparams (PRE_B, PRE_ADD, PRE_SUB, PRE_ZERO; POST_LOAD, POST_ACC, POST_PASSC, POST_CLEAR).
  - a clog2-based channel-width function.
- Sub-module dsp_acc_bank: NCH×PW register file with one combinational read port, one write port with enable, and synchronous reset.
- Top level holds the three pipeline stages, the saturation logic and the handshake.

## Test plan
- Reset: hold RST 2 cycles mid-stream → P=0, out_valid=0, in_ready=1. A following ACC on ch0 with A=2, B=3, pre-op B returns P=6.
- Pre-add and LOAD: A=100, D=20, B=5, C=7, pre-op D−B, LOAD → exactly 3 cycles later P=1507, P_ovf=0.
- Interleaved accumulate: ch0 and ch1 alternate ACC, each with A=1, B=10 (ch0) or B=−4 (ch1), 4 samples each, back-to-back → final P: ch0=40, ch1=−16. P_ch tags are correct.
- Back-pressure: out_ready=0 for 5 cycles with 3 samples in flight → P held stable, in_ready=0. On release, results emerge in order with no loss or duplication.
- Saturation: SAT=1, PW=48, LOAD C=2^47−1, then ACC A=1, B=1 → P=2^47−1, P_ovf=1. With SAT=0, the same sequence gives P=−2^47, P_ovf=1.
- CLEAR/PASSC: CLEAR ch2, then PASSC with C=−9 → P=−9 and acc[2] stays 0. A next ACC on ch2 with A=3, B=3 gives P=9.
